// File: rtl/lsu_port_arbiter_if.sv
// Purpose: bundles the two master request/response ports and the LSU lines of the arbiter.
// Latency: none, this is wiring only.
// Backpressure: gnt is the only stall signal; a master holds req and its fields until gnt.
interface lsu_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  m0_req_i;
   logic [ADDR_WIDTH-1:0] m0_addr_i;
   logic [2:0]            m0_func_i;
   logic                  m0_we_i;
   logic [DATA_WIDTH-1:0] m0_wdata_i;
   logic                  m0_gnt_o;
   logic                  m0_rvalid_o;
   logic [DATA_WIDTH-1:0] m0_rdata_o;

   logic                  m1_req_i;
   logic [ADDR_WIDTH-1:0] m1_addr_i;
   logic [2:0]            m1_func_i;
   logic                  m1_we_i;
   logic [DATA_WIDTH-1:0] m1_wdata_i;
   logic                  m1_gnt_o;
   logic                  m1_rvalid_o;
   logic [DATA_WIDTH-1:0] m1_rdata_o;

   logic [ADDR_WIDTH-1:0] lsu_addr_o;
   logic [2:0]            lsu_func_o;
   logic                  lsu_st_en_o;
   logic [DATA_WIDTH-1:0] lsu_st_data_o;
   logic [DATA_WIDTH-1:0] lsu_ld_data_i;

   // Arbiter side.
   modport slave (
      input  m0_req_i, m0_addr_i, m0_func_i, m0_we_i, m0_wdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      input  m1_req_i, m1_addr_i, m1_func_i, m1_we_i, m1_wdata_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      output lsu_addr_o, lsu_func_o, lsu_st_en_o, lsu_st_data_o,
      input  lsu_ld_data_i
   );

   // Environment side: the two masters plus the LSU.
   modport master (
      output m0_req_i, m0_addr_i, m0_func_i, m0_we_i, m0_wdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      output m1_req_i, m1_addr_i, m1_func_i, m1_we_i, m1_wdata_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      input  lsu_addr_o, lsu_func_o, lsu_st_en_o, lsu_st_data_o,
      output lsu_ld_data_i
   );
endinterface

// File: rtl/lsu_port_arbiter.sv
// Purpose: shares one LSU between m0 (pipeline, high priority) and m1 (loader), with m1 starvation guard.
// Latency: gnt at N, store enable at N+1, response pulse at N+3; one access per 3 cycles.
// Backpressure: gnt only in IDLE; a waiting master keeps req high, m1 wins after STARVE_LIMIT lost rounds.
module lsu_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   lsu_port_arbiter_if.slave   bus
);
   localparam int            CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state;
   logic          owner;       // 0 = m0, 1 = m1
   logic          cap_we;
   logic [CW-1:0] starve_cnt;
   logic          sel_m1;
   logic          gnt0;
   logic          gnt1;

   // Pick a master in IDLE: m1 wins when alone or once it has been passed over STARVE_LIMIT times.
   always_comb begin
      sel_m1 = bus.m1_req_i && (!bus.m0_req_i || (starve_cnt == LIMIT));
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      if (rst_ni && (state == IDLE)) begin
         gnt1 = sel_m1;
         gnt0 = bus.m0_req_i && !sel_m1;
      end
   end

   assign bus.m0_gnt_o = gnt0;
   assign bus.m1_gnt_o = gnt1;

   // Access sequencer: capture on grant, drive LSU, register load data and pulse the owner's response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state             <= IDLE;
         owner             <= 1'b0;
         cap_we            <= 1'b0;
         starve_cnt        <= '0;
         bus.lsu_addr_o    <= '0;
         bus.lsu_func_o    <= '0;
         bus.lsu_st_en_o   <= 1'b0;
         bus.lsu_st_data_o <= '0;
         bus.m0_rvalid_o   <= 1'b0;
         bus.m0_rdata_o    <= '0;
         bus.m1_rvalid_o   <= 1'b0;
         bus.m1_rdata_o    <= '0;
      end else begin
         bus.lsu_st_en_o <= 1'b0;
         bus.m0_rvalid_o <= 1'b0;
         bus.m1_rvalid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  owner             <= gnt1;
                  cap_we            <= gnt1 ? bus.m1_we_i    : bus.m0_we_i;
                  bus.lsu_addr_o    <= gnt1 ? bus.m1_addr_i  : bus.m0_addr_i;
                  bus.lsu_func_o    <= gnt1 ? bus.m1_func_i  : bus.m0_func_i;
                  bus.lsu_st_data_o <= gnt1 ? bus.m1_wdata_i : bus.m0_wdata_i;
                  bus.lsu_st_en_o   <= gnt1 ? bus.m1_we_i    : bus.m0_we_i;
                  state             <= ISSUE;
                  if (gnt1) begin
                     starve_cnt <= '0;
                  end else if (bus.m1_req_i && (starve_cnt != LIMIT)) begin
                     starve_cnt <= starve_cnt + CW'(1);
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               state <= IDLE;
               if (owner) begin
                  bus.m1_rvalid_o <= 1'b1;
                  bus.m1_rdata_o  <= cap_we ? '0 : bus.lsu_ld_data_i;
               end else begin
                  bus.m0_rvalid_o <= 1'b1;
                  bus.m0_rdata_o  <= cap_we ? '0 : bus.lsu_ld_data_i;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
